// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM:
// state codes, ALU operation codes, opcodes and datapath mux selects.
package rv_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_MEM_WB    = 4'd6,
        ST_EXEC_R    = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_ALU_WB    = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JAL       = 4'd11,
        ST_ERROR     = 4'd12
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    // BEQ/BNE test the zero flag, BLT/BGE the signed less-than flag.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic lt);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// Maps funct3/funct7[5] of an R- or I-type instruction to an ALU op code.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                is_imm,
    output logic [ALU_OP_W-1:0] alu_op
);

    // funct7[5] only qualifies SUB for register ops and SRA for both.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory wait states and bus timeout.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes into ERROR.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  i_or_d,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            mem_to_reg,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  pc_src,
    output logic                  mem_err,
    output logic                  illegal,
    output logic [3:0]            state_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 32'd1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_cnt_next;
    logic                  timeout_hit;
    logic                  timeout_err;
    logic [ALU_OP_W-1:0]   dec_op;
    logic [ALU_OP_W-1:0]   alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic                  illegal_err;
`endif

    rv_alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_imm   (state == ST_EXEC_I),
        .alu_op   (dec_op)
    );

    // Expiry is the cycle that would be the MEM_TIMEOUT-th wait; a ready in that cycle wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == CNT_LAST);

    assign alu_control = ALU_CTRL_W'(alu_op);
    assign state_o     = STATE_W'(state);

    // State register, wait counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_err  <= mem_err | timeout_err;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= illegal | illegal_err;
        end
    end
`else
    assign illegal = 1'b0;
`endif

    // Counter restarts on every state change and counts stalled memory cycles.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state_next != state) begin
            wait_cnt_next = '0;
        end else if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        i_or_d      = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = M2R_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_ADD;
        pc_src      = 1'b0;
        timeout_err = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_err = 1'b0;
`endif
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_next  = ST_ERROR;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
                    OP_RTYPE:          state_next = ST_EXEC_R;
                    OP_ITYPE:          state_next = ST_EXEC_I;
                    OP_BRANCH:         state_next = ST_BRANCH;
                    OP_JAL:            state_next = ST_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_err = 1'b1;
                        state_next  = ST_ERROR;
`else
                        state_next  = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ, ST_MEM_WRITE: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = (state == ST_MEM_WRITE);
                if (mem_ready) begin
                    state_next = (state == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_next  = ST_ERROR;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_next = ST_FETCH;
            end
            ST_EXEC_R: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = dec_op;
                state_next = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = dec_op;
                state_next = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                pc_src     = 1'b1;
                pc_en      = branch_taken(funct3, zero, lt);
                state_next = ST_FETCH;
            end
            ST_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                pc_en      = 1'b1;
                pc_src     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed vector table,
// instruction-level reference model with random memory stalls, corner cases.
module tb_rv_multicycle_ctrl;

    localparam int ACW = 6;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic           clk = 1'b0;
    logic           reset;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic           funct7_5;
    logic           zero;
    logic           lt;
    logic           mem_ready;
    logic           pc_en, i_or_d, mem_req, mem_write, ir_write, reg_write;
    logic [1:0]     mem_to_reg, alu_src_a, alu_src_b;
    logic [ACW-1:0] alu_control;
    logic           pc_src, mem_err, illegal;
    logic [3:0]     state_o;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.ALU_CTRL_W(ACW), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .mem_err(mem_err), .illegal(illegal), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0]     st;
        logic           pc_en, i_or_d, mem_req, mem_write, ir_write, reg_write;
        logic [1:0]     m2r, sa, sb;
        logic [ACW-1:0] alu;
        logic           pc_src, mem_err, illegal;
    } obs_t;

    typedef struct {
        logic [6:0]     op;
        logic [2:0]     f3;
        logic           f7, z, l;
        int             len;
        logic [19:0]    path;
        logic [ACW-1:0] alu;
        logic [4:0]     rw, pe;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[21];

    function automatic obs_t base(input logic [3:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a.st = state_o;       a.pc_en = pc_en;         a.i_or_d = i_or_d;
        a.mem_req = mem_req;  a.mem_write = mem_write; a.ir_write = ir_write;
        a.reg_write = reg_write; a.m2r = mem_to_reg;   a.sa = alu_src_a;
        a.sb = alu_src_b;     a.alu = alu_control;     a.pc_src = pc_src;
        a.mem_err = mem_err;  a.illegal = illegal;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every control output of the current cycle, then advance one clock.
    task automatic step(input obs_t e, input string name);
        obs_t a;
        #1;
        a = actual();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got state=%0d outputs=%h expected state=%0d outputs=%h",
                     name, a.st, a, e.st, e);
        end
        @(negedge clk);
    endtask

    function automatic logic [ACW-1:0] ref_alu(input logic [2:0] f3, input logic f7, input logic imm);
        case (f3)
            3'd0:    return (f7 && !imm) ? ACW'(1) : ACW'(0);
            3'd1:    return ACW'(6);
            3'd2:    return ACW'(5);
            3'd4:    return ACW'(4);
            3'd5:    return f7 ? ACW'(8) : ACW'(7);
            3'd6:    return ACW'(3);
            3'd7:    return ACW'(2);
            default: return ACW'(0);
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return l;
        if (f3 == 3'd5) return !l;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input logic l, input int len,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4,
                                input int alu, input logic [4:0] rw, input logic [4:0] pe);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l; v.len = len;
        v.path = {s4, s3, s2, 4'd2, 4'd1};
        v.alu = ACW'(alu); v.rw = rw; v.pe = pe;
        return v;
    endfunction

    // Memory phase: waits>=0 gives that many stall cycles, waits<0 gives random stalls.
    task automatic mem_access(input logic [3:0] st, input logic fetch, input logic store,
                              input int waits, input string tag);
        obs_t e;
        logic rdy;
        int   n;
        n = 0;
        for (int guard = 0; guard < 64; guard++) begin
            if (waits >= 0) rdy = (n >= waits);
            else            rdy = (n >= 4) || ($urandom_range(0, 3) != 0);
            mem_ready   = rdy;
            e           = base(st);
            e.mem_req   = 1'b1;
            e.i_or_d    = !fetch;
            e.mem_write = store;
            if (fetch) begin
                e.sb       = 2'b01;
                e.ir_write = rdy;
                e.pc_en    = rdy;
            end
            step(e, tag);
            if (rdy) break;
            n++;
        end
    endtask

    // One whole instruction, from FETCH entry until the next FETCH entry.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic l, input int fw, input int mw);
        obs_t e;
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z; lt = l;
        mem_access(4'd1, 1'b1, 1'b0, fw, "fetch");
        mem_ready = 1'($urandom_range(0, 1));
        e = base(4'd2); e.sa = 2'b10; e.sb = 2'b10;
        step(e, "decode");
        if (op == OP_LD || op == OP_ST) begin
            mem_ready = 1'($urandom_range(0, 1));
            e = base(4'd3); e.sa = 2'b01; e.sb = 2'b10;
            step(e, "mem_addr");
            mem_access((op == OP_LD) ? 4'd4 : 4'd5, 1'b0, op == OP_ST, mw, "mem_data");
            if (op == OP_LD) begin
                mem_ready = 1'($urandom_range(0, 1));
                e = base(4'd6); e.reg_write = 1'b1; e.m2r = 2'b01;
                step(e, "mem_wb");
            end
        end else if (op == OP_R || op == OP_I) begin
            mem_ready = 1'($urandom_range(0, 1));
            e = base((op == OP_R) ? 4'd7 : 4'd8);
            e.sa = 2'b01; e.sb = (op == OP_I) ? 2'b10 : 2'b00;
            e.alu = ref_alu(f3, f7, op == OP_I);
            step(e, "exec");
            e = base(4'd9); e.reg_write = 1'b1;
            step(e, "alu_wb");
        end else if (op == OP_BR) begin
            mem_ready = 1'($urandom_range(0, 1));
            e = base(4'd10); e.sa = 2'b01; e.alu = ACW'(1); e.pc_src = 1'b1;
            e.pc_en = ref_taken(f3, z, l);
            step(e, "branch");
        end else if (op == OP_JAL) begin
            e = base(4'd11); e.reg_write = 1'b1; e.m2r = 2'b10; e.pc_en = 1'b1; e.pc_src = 1'b1;
            step(e, "jal");
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(base(4'd0), {tag, "_idle"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        e;
        logic [6:0]  rop;
        logic [2:0]  rf3;

        reset = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;

        tbl[0]  = mk(OP_R,   3'd0, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 0, 5'b01000, 5'b00001);
        tbl[1]  = mk(OP_R,   3'd0, 1'b1, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 1, 5'b01000, 5'b00001);
        tbl[2]  = mk(OP_R,   3'd1, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 6, 5'b01000, 5'b00001);
        tbl[3]  = mk(OP_R,   3'd2, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 5, 5'b01000, 5'b00001);
        tbl[4]  = mk(OP_R,   3'd4, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 4, 5'b01000, 5'b00001);
        tbl[5]  = mk(OP_R,   3'd5, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 7, 5'b01000, 5'b00001);
        tbl[6]  = mk(OP_R,   3'd5, 1'b1, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 8, 5'b01000, 5'b00001);
        tbl[7]  = mk(OP_R,   3'd6, 1'b0, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 3, 5'b01000, 5'b00001);
        tbl[8]  = mk(OP_R,   3'd7, 1'b1, 1'b0, 1'b0, 4, 4'd7,  4'd9, 4'd0, 2, 5'b01000, 5'b00001);
        tbl[9]  = mk(OP_I,   3'd0, 1'b1, 1'b0, 1'b0, 4, 4'd8,  4'd9, 4'd0, 0, 5'b01000, 5'b00001);
        tbl[10] = mk(OP_I,   3'd5, 1'b1, 1'b0, 1'b0, 4, 4'd8,  4'd9, 4'd0, 8, 5'b01000, 5'b00001);
        tbl[11] = mk(OP_I,   3'd1, 1'b0, 1'b0, 1'b0, 4, 4'd8,  4'd9, 4'd0, 6, 5'b01000, 5'b00001);
        tbl[12] = mk(OP_LD,  3'd2, 1'b0, 1'b0, 1'b0, 5, 4'd3,  4'd4, 4'd6, 0, 5'b10000, 5'b00001);
        tbl[13] = mk(OP_ST,  3'd2, 1'b0, 1'b0, 1'b0, 4, 4'd3,  4'd5, 4'd0, 0, 5'b00000, 5'b00001);
        tbl[14] = mk(OP_BR,  3'd0, 1'b0, 1'b1, 1'b0, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00101);
        tbl[15] = mk(OP_BR,  3'd1, 1'b0, 1'b1, 1'b0, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00001);
        tbl[16] = mk(OP_BR,  3'd1, 1'b0, 1'b0, 1'b0, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00101);
        tbl[17] = mk(OP_BR,  3'd4, 1'b0, 1'b0, 1'b1, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00101);
        tbl[18] = mk(OP_BR,  3'd5, 1'b0, 1'b0, 1'b1, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00001);
        tbl[19] = mk(OP_BR,  3'd2, 1'b0, 1'b1, 1'b1, 3, 4'd10, 4'd0, 4'd0, 1, 5'b00000, 5'b00001);
        tbl[20] = mk(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 3, 4'd11, 4'd0, 4'd0, 0, 5'b00100, 5'b00101);

        @(negedge clk);
        @(negedge clk);
        step(base(4'd0), "reset_held");
        reset = 1'b1;
        step(base(4'd0), "idle_after_reset");

        // Directed table with zero-wait memory.
        for (int v = 0; v < 21; v++) begin
            opcode = tbl[v].op; funct3 = tbl[v].f3; funct7_5 = tbl[v].f7;
            zero = tbl[v].z; lt = tbl[v].l; mem_ready = 1'b1;
            for (int c = 0; c < tbl[v].len; c++) begin
                #1;
                chk($sformatf("v%0d_c%0d_state", v, c), 32'(state_o), 32'(tbl[v].path[c*4 +: 4]));
                chk($sformatf("v%0d_c%0d_reg_write", v, c), 32'(reg_write), 32'(tbl[v].rw[c]));
                chk($sformatf("v%0d_c%0d_pc_en", v, c), 32'(pc_en), 32'(tbl[v].pe[c]));
                if (c == 2)
                    chk($sformatf("v%0d_alu_control", v), 32'(alu_control), 32'(tbl[v].alu));
                @(negedge clk);
            end
        end

        // Stalled load, and a store that completes just before the timeout would fire.
        run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, 2, 15);

        // Random instruction stream with random stalls.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       rop = OP_R;
                1:       rop = OP_I;
                2:       rop = OP_LD;
                3:       rop = OP_ST;
                4:       rop = OP_BR;
                default: rop = OP_JAL;
            endcase
            rf3 = 3'($urandom_range(0, 7));
            if (rf3 == 3'd3 && rop != OP_BR) rf3 = 3'd0;
            run_instr(rop, rf3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1, -1);
        end

        // Unsupported opcode.
        opcode = OP_BAD; mem_ready = 1'b1;
        e = base(4'd1); e.mem_req = 1'b1; e.sb = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
        step(e, "bad_fetch");
        e = base(4'd2); e.sa = 2'b10; e.sb = 2'b10;
        step(e, "bad_decode");
`ifdef ILLEGAL_TRAP_EN
        e = base(4'd12); e.illegal = 1'b1;
        step(e, "bad_trap");
        step(e, "bad_trap_hold");
`else
        e = base(4'd1); e.mem_req = 1'b1; e.sb = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
        step(e, "bad_nop_fetch");
`endif
        do_reset("rst_after_bad");

        // FETCH never served: ERROR after 16 stall cycles.
        opcode = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = base(4'd1); e.mem_req = 1'b1; e.sb = 2'b01;
            step(e, $sformatf("timeout_wait%0d", i));
        end
        e = base(4'd12); e.mem_err = 1'b1;
        step(e, "timeout_error");
        mem_ready = 1'b1;
        step(e, "timeout_error_hold");

        // Asynchronous reset while in ERROR.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_mem_err", 32'(mem_err), 32'd0);
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(base(4'd0), "idle_after_error");

        // Reset in the middle of an R-type instruction.
        opcode = OP_R; funct3 = 3'd0; funct7_5 = 1'b0; mem_ready = 1'b1;
        e = base(4'd1); e.mem_req = 1'b1; e.sb = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
        step(e, "abort_fetch");
        e = base(4'd2); e.sa = 2'b10; e.sb = 2'b10;
        step(e, "abort_decode");
        #2;
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(base(4'd0), "abort_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
